// File: rtl/accel_pkg.sv
// Shared types and constants for the conv2d data feeders.
// Word width helper, feeder FSM encoding, buffer read latency.
package accel_pkg;

    localparam int MEM_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int word_width(input int bw, input int nc);
        return bw * nc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Shared by the input and weight feeders.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;

    // Storage array, written at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/input_data_feeder.sv
// Streams a block of input words from the buffer to the conv2d
// engine, one word per request, through a small prefetch FIFO.
module input_data_feeder
    import accel_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int REG_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    localparam int W = word_width(BIT_WIDTH, NUM_CHANNEL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_conf_baseaddr,
    input  logic [REG_WIDTH-1:0]  i_conf_numword,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [W-1:0]          i_mem_rdata,
    input  logic                  i_data_req,
    input  logic                  i_data_end,
    output logic [W-1:0]          o_data,
    output logic                  o_data_val
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [REG_WIDTH-1:0]  r_numword;
    logic [REG_WIDTH-1:0]  r_issued;
    logic [REG_WIDTH-1:0]  r_delivered;
    logic [REG_WIDTH-1:0]  r_pending;
    logic                  r_inflight;
    logic [W-1:0]          r_data;
    logic                  r_data_val;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_run;
    logic                  w_abort;
    logic                  w_req;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    logic                  w_empty;
    logic                  w_full;
    logic [W-1:0]          w_fifo_rdata;

    assign w_run   = (r_state == ST_RUN);
    assign w_abort = w_run & i_data_end;
    assign w_req   = w_run & i_data_req;
    // A returning read still needs a slot, so reserve it up front.
    assign w_room  = (int'(w_count) + int'(r_inflight))
                     <= (FIFO_DEPTH - MEM_RD_LAT);
    assign w_issue = w_run & ~i_data_end & ~w_full & w_room
                     & (r_issued < r_numword);
    assign w_pop   = w_run & ~i_data_end & ~w_empty
                     & ((r_pending != '0) | i_data_req);

    assign o_mem_en   = w_issue;
    assign o_mem_addr = w_issue ? r_base + ADDR_WIDTH'(r_issued) : '0;
    assign o_data     = r_data;
    assign o_data_val = r_data_val;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_abort),
        .i_push  (r_inflight),
        .i_wdata (i_mem_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Control FSM with request accounting and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_numword   <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_pending   <= '0;
            r_inflight  <= 1'b0;
            r_data      <= '0;
            r_data_val  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_data_val <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_pop) begin
                r_data     <= w_fifo_rdata;
                r_data_val <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_base      <= i_conf_baseaddr;
                        r_numword   <= i_conf_numword;
                        r_issued    <= '0;
                        r_delivered <= '0;
                        r_pending   <= '0;
                        r_busy      <= 1'b1;
                        if (i_conf_numword == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) r_issued <= r_issued + 1'b1;
                    if (w_pop) r_delivered <= r_delivered + 1'b1;
                    if (w_abort) begin
                        r_pending <= '0;
                    end else begin
                        r_pending <= r_pending + REG_WIDTH'(w_req)
                                     - REG_WIDTH'(w_pop);
                    end
                    if (w_abort || r_delivered == r_numword) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_pending <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_data_feeder.sv
// Randomised bench for input_data_feeder with a buffer model
// and a queue-based scoreboard of delivered words and reads.
module tb_input_data_feeder;

    localparam int BW = 8;
    localparam int NC = 3;
    localparam int AW = 16;
    localparam int RW = 32;
    localparam int FD = 4;
    localparam int W  = BW * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_conf_baseaddr = '0;
    logic [RW-1:0] i_conf_numword = '0;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_en;
    logic [AW-1:0] o_mem_addr;
    logic [W-1:0]  i_mem_rdata;
    logic          i_data_req = 1'b0;
    logic          i_data_end = 1'b0;
    logic [W-1:0]  o_data;
    logic          o_data_val;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [65536];

    always #5 clk = ~clk;

    input_data_feeder #(
        .BIT_WIDTH   (BW),
        .NUM_CHANNEL (NC),
        .ADDR_WIDTH  (AW),
        .REG_WIDTH   (RW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_conf_baseaddr (i_conf_baseaddr),
        .i_conf_numword  (i_conf_numword),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_mem_en        (o_mem_en),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rdata     (i_mem_rdata),
        .i_data_req      (i_data_req),
        .i_data_end      (i_data_end),
        .o_data          (o_data),
        .o_data_val      (o_data_val)
    );

    // Buffer memory: one-cycle read latency.
    always @(posedge clk) begin
        if (o_mem_en) i_mem_rdata <= mem[o_mem_addr];
    end

    int            cyc = 0;
    int            n_done = 0;
    int            n_busy = 0;
    int            done_cyc = 0;
    int            busy_first = -1;
    int            max_occ = 0;
    logic [W-1:0]  q_data [$];
    int            q_vcyc [$];
    logic [AW-1:0] q_rd [$];

    // Observation of outputs on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_data_val) begin
            q_data.push_back(o_data);
            q_vcyc.push_back(cyc);
        end
        if (o_mem_en) q_rd.push_back(o_mem_addr);
        if (o_done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
        if (o_busy) begin
            n_busy = n_busy + 1;
            if (busy_first < 0) busy_first = cyc;
        end
        if (int'(q_rd.size()) - int'(q_data.size()) > max_occ)
            max_occ = int'(q_rd.size()) - int'(q_data.size());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_vcyc.delete();
        q_rd.delete();
        n_done = 0;
        n_busy = 0;
        done_cyc = 0;
        busy_first = -1;
        max_occ = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n,
                            output int s);
        i_start = 1'b1;
        i_conf_baseaddr = b;
        i_conf_numword = RW'(n);
        tick();
        i_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && o_busy; i++) tick();
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b want 0", name, o_busy);
        end
    endtask

    // Scoreboard: words must be buffer[base+k], k in order.
    task automatic check_words(input logic [AW-1:0] b, input int n,
                               input string name);
        logic [AW-1:0] a;
        checks++;
        if (q_data.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d",
                     name, q_data.size(), n);
        end
        for (int k = 0; k < n && k < q_data.size(); k++) begin
            a = b + AW'(k);
            checks++;
            if (q_data[k] !== mem[a]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %0h want %0h",
                         name, k, q_data[k], mem[a]);
            end
        end
    endtask

    task automatic check_reads(input logic [AW-1:0] b, input int n,
                               input string name);
        logic [AW-1:0] a;
        checks++;
        if (q_rd.size() != n) begin
            errors++;
            $display("FAIL %s_nreads: got %0d want %0d",
                     name, q_rd.size(), n);
        end
        for (int k = 0; k < n && k < q_rd.size(); k++) begin
            a = b + AW'(k);
            checks++;
            if (q_rd[k] !== a) begin
                errors++;
                $display("FAIL %s_raddr[%0d]: got %0h want %0h",
                         name, k, q_rd[k], a);
            end
        end
    endtask

    task automatic check_idle_outs(input string name);
        logic [AW+W+3:0] v;
        v = {o_busy, o_done, o_mem_en, o_data_val, o_mem_addr, o_data};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%0h want 0", name, v);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        check_idle_outs("reset_outs");
        rst = 1'b1;
        repeat (2) tick();
        check_idle_outs("after_reset_outs");
    endtask

    // Cold start stream with req held; a start while busy is ignored.
    task automatic run_stream(input string name);
        int s;
        for (int i = 0; i < 6; i++) mem[16'h0010 + i] = W'(16'h0010 + i);
        clear_mon();
        do_start(16'h0010, 6, s);
        i_data_req = 1'b1;
        tick();
        i_start = 1'b1;
        i_conf_baseaddr = 16'h0500;
        i_conf_numword = 2;
        tick();
        i_start = 1'b0;
        wait_idle(40, name);
        i_data_req = 1'b0;
        repeat (3) tick();
        check_words(16'h0010, 6, name);
        check_reads(16'h0010, 6, name);
        checks++;
        if (q_vcyc.size() > 0 && q_vcyc[0] - busy_first != 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 3",
                     name, q_vcyc[0] - busy_first);
        end
        for (int k = 1; k < q_vcyc.size(); k++) begin
            checks++;
            if (q_vcyc[k] != q_vcyc[0] + k) begin
                errors++;
                $display("FAIL %s_gap[%0d]: got %0d want %0d",
                         name, k, q_vcyc[k], q_vcyc[0] + k);
            end
        end
        checks++;
        if (n_done != 1 || q_vcyc.size() == 0 ||
            done_cyc != q_vcyc[q_vcyc.size()-1] + 1) begin
            errors++;
            $display("FAIL %s_done: n=%0d at %0d want 1 after last val",
                     name, n_done, done_cyc);
        end
    endtask

    task automatic test_stream();
        run_stream("stream");
    endtask

    // Sparse requests, buffer address wrapping past 0xFFFF.
    task automatic test_pulsed_req();
        int s;
        int q_rc [$];
        logic [AW-1:0] b;
        b = 16'hFFFD;
        clear_mon();
        do_start(b, 8, s);
        repeat (5) tick();
        checks++;
        if (q_rd.size() != FD || q_data.size() != 0) begin
            errors++;
            $display("FAIL pulsed_stall: reads=%0d vals=%0d want %0d/0",
                     q_rd.size(), q_data.size(), FD);
        end
        for (int k = 0; k < 8; k++) begin
            i_data_req = 1'b1;
            q_rc.push_back(cyc + 1);
            tick();
            i_data_req = 1'b0;
            repeat (2) tick();
        end
        wait_idle(40, "pulsed");
        repeat (2) tick();
        check_words(b, 8, "pulsed");
        check_reads(b, 8, "pulsed");
        for (int k = 0; k < 8 && k < q_vcyc.size(); k++) begin
            checks++;
            if (q_vcyc[k] != q_rc[k] + 1) begin
                errors++;
                $display("FAIL pulsed_lat[%0d]: val at %0d want %0d",
                         k, q_vcyc[k], q_rc[k] + 1);
            end
        end
        checks++;
        if (max_occ > FD + 1) begin
            errors++;
            $display("FAIL pulsed_occ: got %0d want <= %0d",
                     max_occ, FD + 1);
        end
    endtask

    // Requests issued before any data is available.
    task automatic test_burst();
        int s;
        logic [AW-1:0] b;
        b = AW'($urandom_range(0, 16'hFF00));
        clear_mon();
        do_start(b, 5, s);
        i_data_req = 1'b1;
        repeat (5) tick();
        i_data_req = 1'b0;
        wait_idle(40, "burst");
        repeat (4) tick();
        check_words(b, 5, "burst");
        for (int k = 1; k < q_vcyc.size(); k++) begin
            checks++;
            if (q_vcyc[k] != q_vcyc[0] + k) begin
                errors++;
                $display("FAIL burst_gap[%0d]: got %0d want %0d",
                         k, q_vcyc[k], q_vcyc[0] + k);
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL burst_done: got %0d want 1", n_done);
        end
    endtask

    // Abort mid-transfer, then a fresh transfer must see no stale data.
    task automatic test_abort();
        int s;
        int e;
        int nv;
        logic [AW-1:0] b;
        b = AW'($urandom_range(16'h0200, 16'hF000));
        clear_mon();
        do_start(b, 10, s);
        i_data_req = 1'b1;
        for (int i = 0; i < 30 && q_data.size() < 4; i++) tick();
        i_data_end = 1'b1;
        e = cyc + 1;
        tick();
        i_data_end = 1'b0;
        i_data_req = 1'b0;
        wait_idle(10, "abort");
        repeat (4) tick();
        nv = q_data.size();
        checks++;
        if (nv < 4 || nv >= 10) begin
            errors++;
            $display("FAIL abort_count: got %0d want 4..9", nv);
        end
        if (nv > 0) check_words(b, nv, "abort");
        checks++;
        if (nv > 0 && q_vcyc[nv-1] > e) begin
            errors++;
            $display("FAIL abort_late_val: at %0d want <= %0d",
                     q_vcyc[nv-1], e);
        end
        checks++;
        if (n_done != 1 || done_cyc != e + 1) begin
            errors++;
            $display("FAIL abort_done: n=%0d at %0d want 1 at %0d",
                     n_done, done_cyc, e + 1);
        end
        clear_mon();
        do_start(16'h0100, 3, s);
        i_data_req = 1'b1;
        wait_idle(40, "restart");
        i_data_req = 1'b0;
        repeat (2) tick();
        check_words(16'h0100, 3, "restart");
    endtask

    task automatic test_zero();
        int s;
        clear_mon();
        do_start(AW'($urandom), 0, s);
        repeat (4) tick();
        checks++;
        if (n_busy != 1 || busy_first != s + 1) begin
            errors++;
            $display("FAIL zero_busy: cycles=%0d first=%0d want 1 at %0d",
                     n_busy, busy_first, s + 1);
        end
        checks++;
        if (n_done != 1 || done_cyc != s + 1) begin
            errors++;
            $display("FAIL zero_done: n=%0d at %0d want 1 at %0d",
                     n_done, done_cyc, s + 1);
        end
        checks++;
        if (q_rd.size() != 0 || q_data.size() != 0) begin
            errors++;
            $display("FAIL zero_activity: reads=%0d vals=%0d want 0/0",
                     q_rd.size(), q_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_mon();
        do_start(AW'($urandom_range(0, 16'hF000)), 12, s);
        i_data_req = 1'b1;
        for (int i = 0; i < 30 && q_data.size() < 2; i++) tick();
        rst = 1'b0;
        #1;
        check_idle_outs("midrst_outs");
        i_data_req = 1'b0;
        repeat (3) tick();
        check_idle_outs("midrst_hold");
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL midrst_done: got %0d want 0", n_done);
        end
        rst = 1'b1;
        repeat (2) tick();
        run_stream("post_rst");
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = W'($urandom);
        test_reset();
        test_stream();
        test_pulsed_req();
        test_burst();
        test_abort();
        test_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t want finish", $time);
        $fatal(1);
    end

endmodule
